// File: rtl/hermes_skid_crossbar.sv
// Hermes crossbar with a small skid FIFO on every output. The FIFO keeps ack_o independent of credit_i.
// Optional per-output forwarded-flit counters are built only when HERMES_XBAR_STATS_EN is defined.
module hermes_skid_crossbar #(
  parameter  int unsigned NPORT     = 5,
  parameter  int unsigned FLIT_SIZE = 32,
  parameter  int unsigned BUF_DEPTH = 2,
  localparam int unsigned PW        = $clog2(NPORT)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NPORT-1:0]                    data_av_i,
  input  logic [NPORT-1:0][FLIT_SIZE-1:0]     data_i,
  input  logic [NPORT-1:0]                    free_i,
  input  logic [NPORT-1:0][PW-1:0]            inport_i,
  input  logic [NPORT-1:0][PW-1:0]            outport_i,
  input  logic [NPORT-1:0]                    credit_i,
  output logic [NPORT-1:0]                    ack_o,
  output logic [NPORT-1:0]                    tx_o,
  output logic [NPORT-1:0][FLIT_SIZE-1:0]     data_o,
  output logic [NPORT-1:0][15:0]              flit_cnt_o
);

  localparam int unsigned PTRW = $clog2(BUF_DEPTH);
  localparam int unsigned CW   = PTRW + 1;

  logic [FLIT_SIZE-1:0] r_mem    [NPORT][BUF_DEPTH];
  logic [PTRW-1:0]      r_wr_ptr [NPORT];
  logic [PTRW-1:0]      r_rd_ptr [NPORT];
  logic [CW-1:0]        r_count  [NPORT];

  logic [NPORT-1:0] w_full;
  logic [NPORT-1:0] w_push;
  logic [NPORT-1:0] w_pop;

  // Per-output push/pop; a full buffer refuses a push even when it pops in the same cycle.
  always_comb begin
    w_full = '0;
    w_push = '0;
    w_pop  = '0;
    for (int o = 0; o < NPORT; o++) begin
      w_full[o] = (r_count[o] == CW'(BUF_DEPTH));
      w_push[o] = !rst_i && !free_i[o] && data_av_i[inport_i[o]] && !w_full[o];
      w_pop[o]  = !rst_i && (r_count[o] != '0) && credit_i[o];
    end
  end

  // Input-side acknowledge depends only on the connection table and buffer occupancy.
  always_comb begin
    ack_o = '0;
    for (int i = 0; i < NPORT; i++) begin
      ack_o[i] = !rst_i && data_av_i[i] && !free_i[outport_i[i]] &&
                 (inport_i[outport_i[i]] == PW'(i)) && !w_full[outport_i[i]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int o = 0; o < NPORT; o++) begin
        r_wr_ptr[o] <= '0;
        r_rd_ptr[o] <= '0;
        r_count[o]  <= '0;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (w_push[o]) r_wr_ptr[o] <= r_wr_ptr[o] + PTRW'(1);
        if (w_pop[o])  r_rd_ptr[o] <= r_rd_ptr[o] + PTRW'(1);
        case ({w_push[o], w_pop[o]})
          2'b10:   r_count[o] <= r_count[o] + CW'(1);
          2'b01:   r_count[o] <= r_count[o] - CW'(1);
          default: r_count[o] <= r_count[o];
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk_i) begin
    for (int o = 0; o < NPORT; o++) begin
      if (w_push[o]) r_mem[o][r_wr_ptr[o]] <= data_i[inport_i[o]];
    end
  end

  always_comb begin
    tx_o   = '0;
    data_o = '0;
    for (int o = 0; o < NPORT; o++) begin
      tx_o[o] = !rst_i && (r_count[o] != '0);
      if (tx_o[o]) data_o[o] = r_mem[o][r_rd_ptr[o]];
    end
  end

`ifdef HERMES_XBAR_STATS_EN
  logic [NPORT-1:0][15:0] r_flit_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flit_cnt <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (w_pop[o]) r_flit_cnt[o] <= r_flit_cnt[o] + 16'd1;
      end
    end
  end

  assign flit_cnt_o = r_flit_cnt;
`else
  assign flit_cnt_o = '0;
`endif

endmodule

// File: doc/hermes_skid_crossbar.md
HERMES_SKID_CROSSBAR -- requirements
Module: hermes_skid_crossbar

Interface
REQ-001 Parameter NPORT, default 5, SHALL set the port count; indices are EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
REQ-002 Parameter FLIT_SIZE, default 32, SHALL set the flit width in bits.
REQ-003 Parameter BUF_DEPTH, default 2, SHALL set per-output buffer depth; legal values are powers of two, at least 2.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 data_av_i  input  [NPORT] x 1  SHALL flag a valid flit at the head of each input buffer.
REQ-007 data_i  input  [NPORT] x FLIT_SIZE  SHALL carry the head flit of each input buffer.
REQ-008 free_i  input  [NPORT] x 1  SHALL be per output: 1 = output unallocated, 0 = connected.
REQ-009 inport_i  input  [NPORT] x $clog2(NPORT)  SHALL be per output: the source input of the connection.
REQ-010 outport_i  input  [NPORT] x $clog2(NPORT)  SHALL be per input: the destination output of the connection.
REQ-011 credit_i  input  [NPORT] x 1  SHALL be per output: 1 = downstream accepts a flit this cycle.
REQ-012 ack_o  output  [NPORT] x 1  SHALL be per input: 1 = head flit consumed this cycle.
REQ-013 tx_o  output  [NPORT] x 1  SHALL be per output: 1 = data_o is valid.
REQ-014 data_o  output  [NPORT] x FLIT_SIZE  SHALL be per output: the flit at the head of that output's buffer.
REQ-015 flit_cnt_o  output  [NPORT] x 16  SHALL be per output: the forwarded-flit counter (see REQ-032).

Function
REQ-016 Each output o SHALL own a BUF_DEPTH-entry FIFO with read/write pointers and an occupancy counter of width $clog2(BUF_DEPTH)+1.
REQ-017 push[o] SHALL be !free_i[o] && data_av_i[inport_i[o]] && (count[o] < BUF_DEPTH), pushing data_i[inport_i[o]].
REQ-018 ack_o[i] SHALL be 1 only when data_av_i[i], !free_i[outport_i[i]], inport_i[outport_i[i]] == i and output outport_i[i] is not full.
REQ-019 ack_o SHALL have no combinational dependence on credit_i; the buffer breaks that path.
REQ-020 tx_o[o] SHALL equal (count[o] != 0); data_o[o] SHALL be the head entry when tx_o[o]=1 and all zeros otherwise.
REQ-021 pop[o] SHALL be tx_o[o] && credit_i[o]; credit_i while empty SHALL be ignored.
REQ-022 Latency from ack_o[i]=1 to the flit appearing on tx_o/data_o of an empty output SHALL be exactly 1 cycle.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; a full buffer SHALL refuse push even if popping that cycle.
REQ-024 With BUF_DEPTH >= 2 and credit_i held at 1, an output SHALL sustain 1 flit/cycle.
REQ-025 Pointers SHALL wrap modulo BUF_DEPTH; count SHALL never exceed BUF_DEPTH or go below 0.
REQ-026 When free_i[o] rises while count[o] > 0, buffered flits SHALL still drain in order; only new pushes stop.
REQ-027 Flits SHALL leave each output in push order; outputs SHALL be mutually independent.

Reset
REQ-028 While rst_i=1, all pointers, counts and flit_cnt_o SHALL be 0, and ack_o, tx_o and data_o SHALL be 0 (data_o all zeros).
REQ-029 Reset asserted mid-transfer SHALL discard buffered flits immediately and asynchronously.
REQ-030 After rst_i falls, the first push SHALL be possible at the first rising clk_i edge.

Configuration
REQ-031 Macro HERMES_XBAR_STATS_EN SHALL control the statistics feature.
REQ-032 With HERMES_XBAR_STATS_EN defined, flit_cnt_o[o] SHALL increment by 1 on each pop[o] and wrap from 0xFFFF to 0x0000.
REQ-033 Without HERMES_XBAR_STATS_EN, flit_cnt_o SHALL be tied to 0 and no counter registers SHALL be synthesised; REQ-016 to REQ-027 are unaffected.

Verification
REQ-034 Bench: input 4 connected to output 0 (free_i[0]=0, inport_i[0]=4), credit_i[0]=1, flits 0xA0..0xA7 on consecutive cycles -> ack_o[4]=1 every cycle; tx_o[0]=1 one cycle later; 0xA0..0xA7 out in order.
REQ-035 Bench: same connection, credit_i[0]=0 -> two flits accepted, then ack_o[4]=0; raising credit_i[0] -> ack_o[4] returns the cycle after the first pop; no flit lost or duplicated.
REQ-036 Bench: input 1 presents data_av_i with outport_i[1]=3 while free_i[3]=1 -> ack_o[1]=0 and tx_o[3]=0 indefinitely.
REQ-037 Bench: two flits buffered at output 2, then free_i[2]=1 -> both drain in order; count reaches 0; no further pushes.
REQ-038 Bench: rst_i pulsed with one flit in each buffer -> tx_o, ack_o, data_o and flit_cnt_o go to 0 without a clock edge.
REQ-039 Bench: with HERMES_XBAR_STATS_EN, 65537 flits through output 0 -> flit_cnt_o[0]=1; without the macro -> flit_cnt_o[0]=0 throughout.
